// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem req/ack handshake and
// feeds IF/ID through an output register backed by a one-entry skid buffer.
module pc_fetch_ctrl #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 branch,
    input  logic                 zero,
    input  logic [CPU_WIDTH-1:0] pc_shift,
    input  logic                 jump,
    input  logic [CPU_WIDTH-1:0] jump_tgt,
    input  logic                 stall,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic [CPU_WIDTH-1:0] pc_add4,
    output logic                 flush_ifid,
    output logic                 flush_idex
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

    state_t               state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                 if_valid_q, if_valid_d;
    logic [CPU_WIDTH-1:0] inst_q, inst_d;
    logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [CPU_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic [CPU_WIDTH-1:0] skid_pc_q, skid_pc_d;

    logic                 taken;
    logic                 redirect;
    logic [CPU_WIDTH-1:0] raw_target;
    logic [CPU_WIDTH-1:0] target;
    logic                 xfer;
    logic                 deliver;
    logic                 consume;

    // The taken branch is older than the jump in ID, so it wins the redirect.
    always_comb begin
        taken      = branch & zero;
        redirect   = taken | jump;
        raw_target = taken ? pc_shift : jump_tgt;
        target     = {raw_target[CPU_WIDTH-1:2], 2'b00};
        flush_ifid = redirect;
        flush_idex = taken;
    end

    // Request is held stable from issue to ack: WAIT and DROP replay req_addr.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        unique case (state_q)
            ST_BOOT: begin
                imem_req  = 1'b0;
                imem_addr = pc_q;
            end
            ST_FETCH: begin
                imem_req  = !skid_valid_q;
                imem_addr = pc_q;
            end
            ST_WAIT, ST_DROP: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = pc_q;
            end
        endcase
    end

    always_comb begin
        xfer    = imem_req & imem_ack;
        deliver = xfer & !redirect & ((state_q == ST_FETCH) || (state_q == ST_WAIT));
        consume = if_valid_q & !stall;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    pc_d = target;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem_req && !imem_ack) begin
                        state_d    = ST_DROP;
                        req_addr_d = pc_q;
                    end
                end else if (xfer) begin
                    pc_d = pc_q + PC_STEP;
                end else if (imem_req) begin
                    state_d    = ST_WAIT;
                    req_addr_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_ack ? ST_FETCH : ST_DROP;
                end else if (imem_ack) begin
                    pc_d    = req_addr_q + PC_STEP;
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Output register drains from the skid first so ordering is preserved.
    always_comb begin
        if_valid_d   = if_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (redirect) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                inst_d       = skid_inst_q;
                inst_pc_d    = skid_pc_q;
                if_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
                if (deliver) begin
                    skid_inst_d  = imem_rdata;
                    skid_pc_d    = imem_addr;
                    skid_valid_d = 1'b1;
                end
            end else if (deliver) begin
                inst_d     = imem_rdata;
                inst_pc_d  = imem_addr;
                if_valid_d = 1'b1;
            end else begin
                if_valid_d = 1'b0;
            end
        end else if (deliver) begin
            if (!if_valid_q) begin
                inst_d     = imem_rdata;
                inst_pc_d  = imem_addr;
                if_valid_d = 1'b1;
            end else begin
                skid_inst_d  = imem_rdata;
                skid_pc_d    = imem_addr;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            req_addr_q   <= '0;
            if_valid_q   <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            if_valid_q   <= if_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        if_valid = if_valid_q;
        inst     = inst_q;
        inst_pc  = inst_pc_q;
        pc_add4  = inst_pc_q + PC_STEP;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: fixed stimulus steps with hand-worked
// expectations; instruction memory returns addr ^ 0xDEAD0000.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    logic        clk;
    logic        rst;
    logic        branch;
    logic        zero;
    logic [31:0] pc_shift;
    logic        jump;
    logic [31:0] jump_tgt;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_add4;
    logic        flush_ifid;
    logic        flush_idex;

    int errors = 0;
    int checks = 0;

    pc_fetch_ctrl #(.CPU_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .branch     (branch),
        .zero       (zero),
        .pc_shift   (pc_shift),
        .jump       (jump),
        .jump_tgt   (jump_tgt),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc_add4    (pc_add4),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex)
    );

    assign imem_rdata = imem_addr ^ TAG;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; branch = 1'b0; zero = 1'b0; pc_shift = '0;
        jump = 1'b0; jump_tgt = '0; stall = 1'b0; imem_ack = 1'b1;

        #12;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);

        tick();
        chk("f0_req", {31'b0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'h0);
        chk("f0_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("f1_addr", imem_addr, 32'h4);
        chk("f1_if_valid", {31'b0, if_valid}, 32'd1);
        chk("f1_inst_pc", inst_pc, 32'h0);
        chk("f1_inst", inst, 32'hDEAD_0000);
        chk("f1_pc_add4", pc_add4, 32'h4);
        tick();
        chk("f2_addr", imem_addr, 32'h8);
        chk("f2_inst_pc", inst_pc, 32'h4);
        chk("f2_inst", inst, 32'hDEAD_0004);

        // Taken branch and jump together: branch wins.
        branch = 1'b1; zero = 1'b1; pc_shift = 32'h100; jump = 1'b1; jump_tgt = 32'h200;
        #1;
        chk("br_flush_ifid", {31'b0, flush_ifid}, 32'd1);
        chk("br_flush_idex", {31'b0, flush_idex}, 32'd1);
        tick();
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        #1;
        chk("br_addr", imem_addr, 32'h100);
        chk("br_if_valid", {31'b0, if_valid}, 32'd0);
        chk("br_flush_clear", {31'b0, flush_ifid}, 32'd0);
        tick();
        chk("br_inst_pc", inst_pc, 32'h100);
        chk("br_inst", inst, 32'hDEAD_0100);
        chk("br_next_addr", imem_addr, 32'h104);

        // Jump to 0x10, then a slow request that gets redirected mid-wait.
        jump = 1'b1; jump_tgt = 32'h10;
        #1;
        chk("j10_flush_idex", {31'b0, flush_idex}, 32'd0);
        tick();
        jump = 1'b0; imem_ack = 1'b0;
        #1;
        chk("w_req", {31'b0, imem_req}, 32'd1);
        chk("w_addr0", imem_addr, 32'h10);
        tick();
        chk("w_addr1", imem_addr, 32'h10);
        chk("w_req1", {31'b0, imem_req}, 32'd1);
        tick();
        branch = 1'b1; zero = 1'b1; pc_shift = 32'h40;
        #1;
        chk("w_addr2", imem_addr, 32'h10);
        chk("w_br_flush_idex", {31'b0, flush_idex}, 32'd1);
        tick();
        branch = 1'b0; zero = 1'b0; imem_ack = 1'b1;
        #1;
        chk("drop_addr", imem_addr, 32'h10);
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        chk("drop_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("drop_discard", {31'b0, if_valid}, 32'd0);
        chk("after_drop_addr", imem_addr, 32'h40);
        tick();
        chk("t40_inst_pc", inst_pc, 32'h40);
        chk("t40_inst", inst, 32'hDEAD_0040);
        chk("t40_addr", imem_addr, 32'h44);

        // Three stall cycles: 0x44 goes to the skid, then requests stop.
        stall = 1'b1;
        tick();
        chk("st1_req", {31'b0, imem_req}, 32'd0);
        chk("st1_inst", inst, 32'hDEAD_0040);
        chk("st1_inst_pc", inst_pc, 32'h40);
        tick();
        chk("st2_req", {31'b0, imem_req}, 32'd0);
        chk("st2_inst_pc", inst_pc, 32'h40);
        tick();
        stall = 1'b0;
        #1;
        chk("st3_req", {31'b0, imem_req}, 32'd0);
        chk("st3_if_valid", {31'b0, if_valid}, 32'd1);
        tick();
        chk("skid_inst_pc", inst_pc, 32'h44);
        chk("skid_inst", inst, 32'hDEAD_0044);
        chk("skid_resume_req", {31'b0, imem_req}, 32'd1);
        chk("skid_resume_addr", imem_addr, 32'h48);
        tick();
        chk("post_skid_inst_pc", inst_pc, 32'h48);

        // Jump alone to an unaligned target.
        jump = 1'b1; jump_tgt = 32'h203;
        #1;
        chk("ja_flush_ifid", {31'b0, flush_ifid}, 32'd1);
        chk("ja_flush_idex", {31'b0, flush_idex}, 32'd0);
        tick();
        jump = 1'b0;
        #1;
        chk("ja_addr", imem_addr, 32'h200);
        chk("ja_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("ja_inst_pc", inst_pc, 32'h200);
        chk("ja_pc_add4", pc_add4, 32'h204);

        // Reset in the middle of a WAIT.
        imem_ack = 1'b0;
        tick();
        chk("rw_addr", imem_addr, 32'h204);
        chk("rw_req", {31'b0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_rst_req", {31'b0, imem_req}, 32'd0);
        chk("rw_rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rw_rst_inst_pc", inst_pc, 32'h0);
        chk("rw_rst_inst", inst, 32'h0);
        tick();
        rst = 1'b0; imem_ack = 1'b1;
        #1;
        chk("rw_boot_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("rw_f_addr", imem_addr, 32'h0);
        chk("rw_f_req", {31'b0, imem_req}, 32'd1);
        tick();
        chk("rw_inst_pc", inst_pc, 32'h0);
        chk("rw_if_valid", {31'b0, if_valid}, 32'd1);

        // pc_add4 and pc wrap at the top of the address space.
        jump = 1'b1; jump_tgt = 32'hFFFF_FFFF;
        tick();
        jump = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_add4", pc_add4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer for the five-stage pipeline.
- Owns the PC register and chooses the next PC: sequential, taken branch from EX, or jump from ID.
- Runs the instruction-memory request/acknowledge handshake and presents fetched instructions to IF/ID through a 1-entry output register plus a 1-entry skid buffer.
- Generates the IF/ID and ID/EX flushes on redirect.

Parameters:
CPU_WIDTH, 32, width of PC, targets and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
branch  input  1  EX-stage instruction is a branch
zero  input  1  EX-stage branch condition true
pc_shift  input  CPU_WIDTH  branch target from EX
jump  input  1  ID-stage unconditional jump
jump_tgt  input  CPU_WIDTH  jump target from ID
stall  input  1  hazard unit: IF/ID must not consume this cycle
imem_req  output  1  instruction fetch request
imem_addr  output  CPU_WIDTH  fetch address
imem_ack  input  1  transfer completes on cycle with imem_req & imem_ack
imem_rdata  input  CPU_WIDTH  instruction, valid on transfer cycle
if_valid  output  1  inst/inst_pc hold a valid instruction
inst  output  CPU_WIDTH  fetched instruction
inst_pc  output  CPU_WIDTH  address of inst
pc_add4  output  CPU_WIDTH  inst_pc + 4, wraps mod 2^CPU_WIDTH
flush_ifid  output  1  combinational, kill IF/ID contents
flush_idex  output  1  combinational, kill ID/EX contents

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=BOOT, if_valid=0, skid empty, inst=0, inst_pc=0, imem_req=0.
  - Any outstanding request is abandoned.
- Handshake rule: once imem_req is high without ack, imem_req and imem_addr stay stable until the ack cycle.
- States:
  - BOOT: imem_req=0; go to FETCH next cycle.
  - FETCH: imem_req = !skid_valid; imem_addr = pc.
    - req & ack: deliver, pc <= pc+4, stay in FETCH.
    - req & !ack: latch req_addr=pc, go to WAIT.
  - WAIT: imem_req=1, imem_addr=req_addr. On ack: deliver, pc <= req_addr+4, go to FETCH.
  - DROP: imem_req=1, imem_addr=req_addr. On ack: discard data, go to FETCH.
- Deliver:
  - If !if_valid or !stall: load output register (inst, inst_pc=transfer addr, if_valid=1).
  - Otherwise: load skid buffer.
- Consume (if_valid & !stall):
  - Skid valid: output register takes skid, skid empties.
  - Else if no same-cycle delivery: if_valid <= 0.
- Redirect:
  - redirect = (branch & zero) | jump. Taken branch beats jump (older instruction).
  - Target bits [1:0] are forced to 0.
  - Redirect overrides stall and is honoured in every state, including BOOT.
- On redirect:
  - pc <= target; if_valid <= 0; skid empties.
  - flush_ifid=1 in the same cycle. flush_idex=1 only for a taken branch.
  - Any transfer completing that cycle is discarded.
- State after redirect:
  - WAIT without ack goes to DROP.
  - WAIT with ack goes to FETCH.
  - DROP with ack goes to FETCH.
  - DROP without ack stays in DROP; the latest target is kept.
  - FETCH stays in FETCH. An un-acked request issued that cycle goes to DROP with req_addr = the old pc.
- Throughput: one instruction per cycle when ack is same-cycle and stall=0.
- Skid full: no new request is issued until the skid drains.

Test Plan:
- Reset release, ack tied 1, stall 0 -> imem_req=0 in the BOOT cycle. Then addresses 0,4,8,…; if_valid from cycle 2; inst_pc trails imem_addr by 1 cycle; pc_add4 = inst_pc+4.
- Taken branch (branch=1, zero=1, pc_shift=0x100) with jump=1 (jump_tgt=0x200) simultaneous -> flush_ifid=1, flush_idex=1; next imem_addr=0x100; if_valid=0 the next cycle.
- Request at 0x10, ack delayed 3 cycles, taken branch to 0x40 in the 2nd wait cycle -> address held at 0x10 until ack; that data is never presented; the next request is to 0x40.
- stall=1 for 3 cycles with ack=1 -> one transfer lands in the skid, then imem_req=0. inst holds its value. On stall release the skid instruction appears next, with no loss or duplicate.
- jump alone to 0x203 -> target 0x200, flush_ifid=1, flush_idex=0.
- rst asserted during WAIT -> outputs reset immediately; after release, fetch restarts at RESET_PC via BOOT.
